fetch_stage: RTL

//  Instruction-fetch stage of the RISC-V core: owns the program counter, drives the

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_stage.sv | 52 +++++
 2 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus between ROM/control (slave side) and the fetch stage (master side)
interface fetch_if #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA = 32
);
  localparam int AW = $clog2(TAM_POSICIONES);
  logic STALL;
  logic BRANCH_TAKEN;
  logic [TAM_PALABRA-1:0] BRANCH_TARGET;
  logic [AW-1:0] INS_ADDRESS;
  logic [TAM_PALABRA-1:0] INSTRUCTION_IN;
  logic [TAM_PALABRA-1:0] PC_OUT;
  logic [TAM_PALABRA-1:0] IF_ID_PC;
  logic [TAM_PALABRA-1:0] IF_ID_INSTR;
  logic IF_ID_VALID;
  logic MISALIGNED;
  logic [TAM_PALABRA-1:0] FETCH_COUNT;
  modport master (
    input STALL, BRANCH_TAKEN, BRANCH_TARGET, INSTRUCTION_IN,
    output INS_ADDRESS, PC_OUT, IF_ID_PC, IF_ID_INSTR, IF_ID_VALID, MISALIGNED, FETCH_COUNT
  );
  modport slave (
    output STALL, BRANCH_TAKEN, BRANCH_TARGET, INSTRUCTION_IN,
    input INS_ADDRESS, PC_OUT, IF_ID_PC, IF_ID_INSTR, IF_ID_VALID, MISALIGNED, FETCH_COUNT
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch with PC, IF/ID register, branch redirect/flush and stall
module fetch_stage #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA = 32,
  parameter logic [TAM_PALABRA-1:0] RESET_PC = '0
) (
  input logic CLK,
  input logic RST,
  fetch_if.master bus
);
  localparam int AW = $clog2(TAM_POSICIONES);
  localparam logic [TAM_PALABRA-1:0] NOP = TAM_PALABRA'(32'h00000013);
  logic [TAM_PALABRA-1:0] pc_q, pc_d, if_id_pc_q, if_id_pc_d;
  logic [TAM_PALABRA-1:0] if_id_instr_q, if_id_instr_d, fetch_count_q, fetch_count_d;
  logic if_id_valid_q, if_id_valid_d, misaligned_q, misaligned_d;
  logic hold;
  // a taken branch overrides stall: redirect and flush take priority
  always_comb begin
    hold = bus.STALL;
    pc_d = bus.BRANCH_TAKEN ? {bus.BRANCH_TARGET[TAM_PALABRA-1:2], 2'b00} :
           hold ? pc_q : pc_q + TAM_PALABRA'(4);
    if_id_pc_d = bus.BRANCH_TAKEN ? '0 : hold ? if_id_pc_q : pc_q;
    if_id_instr_d = bus.BRANCH_TAKEN ? NOP : hold ? if_id_instr_q : bus.INSTRUCTION_IN;
    if_id_valid_d = bus.BRANCH_TAKEN ? 1'b0 : hold ? if_id_valid_q : 1'b1;
    fetch_count_d = (bus.BRANCH_TAKEN || hold) ? fetch_count_q : fetch_count_q + TAM_PALABRA'(1);
    misaligned_d = bus.BRANCH_TAKEN && (bus.BRANCH_TARGET[1:0] != 2'b00);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= RESET_PC;
      if_id_pc_q <= '0;
      if_id_instr_q <= NOP;
      if_id_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q <= pc_d;
      if_id_pc_q <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      misaligned_q <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  assign bus.INS_ADDRESS = pc_q[AW+1:2];
  assign bus.PC_OUT = pc_q;
  assign bus.IF_ID_PC = if_id_pc_q;
  assign bus.IF_ID_INSTR = if_id_instr_q;
  assign bus.IF_ID_VALID = if_id_valid_q;
  assign bus.MISALIGNED = misaligned_q;
  assign bus.FETCH_COUNT = fetch_count_q;
endmodule
